// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element table for the SRAM BIST controller.
// Each element is described by its direction, op count and backgrounds.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ELEM_0 = 3'd0,
        ELEM_1 = 3'd1,
        ELEM_2 = 3'd2,
        ELEM_3 = 3'd3,
        ELEM_4 = 3'd4,
        ELEM_5 = 3'd5
    } elem_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Background selectors, replicated across the word width by the user.
    localparam logic BG0 = 1'b0;
    localparam logic BG1 = 1'b1;

    localparam elem_e LAST_ELEM = ELEM_5;

    localparam int DRAIN_CYCLES = 2;
    localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);
    typedef logic [DRAIN_W-1:0] drain_cnt_t;
    localparam drain_cnt_t DRAIN_LAST = drain_cnt_t'(DRAIN_CYCLES - 1);

    typedef struct packed {
        logic up;
        logic two_op;
        op_e  first_op;
        logic first_bg;
        logic second_bg;
    } elem_cfg_t;

    typedef struct packed {
        op_e  op;
        logic bg;
    } op_t;

    function automatic elem_cfg_t elem_cfg(elem_e e);
        case (e)
            ELEM_0:  return '{up: 1'b1, two_op: 1'b0, first_op: OP_WRITE, first_bg: BG0, second_bg: BG0};
            ELEM_1:  return '{up: 1'b1, two_op: 1'b1, first_op: OP_READ,  first_bg: BG0, second_bg: BG1};
            ELEM_2:  return '{up: 1'b1, two_op: 1'b1, first_op: OP_READ,  first_bg: BG1, second_bg: BG0};
            ELEM_3:  return '{up: 1'b0, two_op: 1'b1, first_op: OP_READ,  first_bg: BG0, second_bg: BG1};
            ELEM_4:  return '{up: 1'b0, two_op: 1'b1, first_op: OP_READ,  first_bg: BG1, second_bg: BG0};
            ELEM_5:  return '{up: 1'b1, two_op: 1'b0, first_op: OP_READ,  first_bg: BG0, second_bg: BG0};
            default: return '{up: 1'b1, two_op: 1'b0, first_op: OP_READ,  first_bg: BG0, second_bg: BG0};
        endcase
    endfunction

    function automatic logic elem_is_up(elem_e e);
        elem_cfg_t c = elem_cfg(e);
        return c.up;
    endfunction

    function automatic logic elem_is_two_op(elem_e e);
        elem_cfg_t c = elem_cfg(e);
        return c.two_op;
    endfunction

    // The second op of a two-op element is always the write.
    function automatic op_t elem_op(elem_e e, logic phase);
        elem_cfg_t c = elem_cfg(e);
        op_t       o;
        if (phase) begin
            o.op = OP_WRITE;
            o.bg = c.second_bg;
        end else begin
            o.op = c.first_op;
            o.bg = c.first_bg;
        end
        return o;
    endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// Port-0 bus of a single-port RW SRAM macro: BIST drives it (master),
// the macro answers on dout0 (slave).
interface sram_march_bist_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
);

    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport master (
        output csb0,
        output web0,
        output addr0,
        output din0,
        input  dout0
    );

    modport slave (
        input  csb0,
        input  web0,
        input  addr0,
        input  din0,
        output dout0
    );

endinterface

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down word-address counter for march elements; tc_o flags
// the last address in the current direction (N-1 going up, 0 going down).
module sram_bist_addr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  load_up_i,
    input  logic                  step_i,
    input  logic                  up_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  tc_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_up_i ? '0 : ADDR_MAX;
        end else if (step_i) begin
            addr_d = up_i ? addr_q + ADDR_ONE : addr_q - ADDR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign tc_o   = up_i ? (addr_q == ADDR_MAX) : (addr_q == '0);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller: issues one macro op per clock while in RUN,
// compares read data two stages later and records the first failure.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int ERR_W      = 8
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [ERR_W-1:0]      err_count,
    sram_march_bist_if.master     mem
);

    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    state_e     state_q, state_d;
    elem_e      elem_q, elem_d;
    logic       phase_q, phase_d;
    drain_cnt_t drain_q, drain_d;

    logic                  start_ok;
    logic                  last_phase;
    logic                  cur_up;
    elem_e                 elem_nxt;
    op_t                   cur_op;
    logic                  issue_rd;
    logic                  ag_load, ag_load_up, ag_step, ag_tc;
    logic [ADDR_WIDTH-1:0] ag_addr;

    assign start_ok   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign cur_op     = elem_op(elem_q, phase_q);
    assign cur_up     = elem_is_up(elem_q);
    assign last_phase = phase_q || !elem_is_two_op(elem_q);
    assign elem_nxt   = elem_e'(elem_q + 3'd1);
    assign issue_rd   = (state_q == S_RUN) && (cur_op.op == OP_READ);

    sram_bist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk0),
        .rst_n     (rst0_n),
        .load_i    (ag_load),
        .load_up_i (ag_load_up),
        .step_i    (ag_step),
        .up_i      (cur_up),
        .addr_o    (ag_addr),
        .tc_o      (ag_tc)
    );

    // ---------------------------------------------------------------
    // FSM and op sequencing. The (elem, phase, address) pointer names the
    // op presented to the macro in the current RUN cycle.
    // ---------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q <= S_IDLE;
            elem_q  <= ELEM_0;
            phase_q <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
        end
    end

    // NOTE: every signal gets a default first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        phase_d    = phase_q;
        drain_d    = drain_q;
        ag_load    = 1'b0;
        ag_load_up = 1'b1;
        ag_step    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    elem_d     = ELEM_0;
                    phase_d    = 1'b0;
                    ag_load    = 1'b1;
                    ag_load_up = elem_is_up(ELEM_0);
                end
            end
            S_RUN: begin
                if (!last_phase) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!ag_tc) begin
                        ag_step = 1'b1;
                    end else if (elem_q == LAST_ELEM) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        elem_d     = elem_nxt;
                        ag_load    = 1'b1;
                        ag_load_up = elem_is_up(elem_nxt);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + drain_cnt_t'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    // Macro port is decoded from registered state, so an async reset
    // deselects the macro without waiting for a clock.
    always_comb begin
        mem.csb0  = 1'b1;
        mem.web0  = 1'b1;
        mem.addr0 = '0;
        mem.din0  = '0;
        if (state_q == S_RUN) begin
            mem.csb0  = 1'b0;
            mem.addr0 = ag_addr;
            if (cur_op.op == OP_WRITE) begin
                mem.web0 = 1'b0;
                mem.din0 = {DATA_WIDTH{cur_op.bg}};
            end
        end
    end

    // ---------------------------------------------------------------
    // Compare pipeline: stage 1 travels with the op the macro captures,
    // stage 2 holds the compare of stage 1 against the returned dout0.
    // ---------------------------------------------------------------
    logic                  s1_vld_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    elem_e                 s1_elem_q;
    logic [DATA_WIDTH-1:0] s1_exp_q;
    logic                  s2_vld_q;
    logic                  s2_miss_q;
    logic [ADDR_WIDTH-1:0] s2_addr_q;
    elem_e                 s2_elem_q;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_elem_q <= ELEM_0;
            s1_exp_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_miss_q <= 1'b0;
            s2_addr_q <= '0;
            s2_elem_q <= ELEM_0;
        end else begin
            s1_vld_q  <= issue_rd;
            s1_addr_q <= ag_addr;
            s1_elem_q <= elem_q;
            s1_exp_q  <= {DATA_WIDTH{cur_op.bg}};
            s2_vld_q  <= s1_vld_q;
            s2_miss_q <= (mem.dout0 != s1_exp_q);
            s2_addr_q <= s1_addr_q;
            s2_elem_q <= s1_elem_q;
        end
    end

    // ---------------------------------------------------------------
    // Result registers
    // ---------------------------------------------------------------
    logic                  fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]            fail_elem_q;
    logic [ERR_W-1:0]      err_count_q;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_count_q <= '0;
        end else if (start_ok) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_count_q <= '0;
        end else if (s2_vld_q && s2_miss_q) begin
            fail_q <= 1'b1;
            if (err_count_q != '1) begin
                err_count_q <= err_count_q + ERR_ONE;
            end
            // Only the first mismatch of a run is located.
            if (!fail_q) begin
                fail_addr_q <= s2_addr_q;
                fail_elem_q <= s2_elem_q;
            end
        end
    end

    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign err_count = err_count_q;

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

March C- built-in self-test controller for single-port RW SRAM macros. It sits directly upstream of the macro's port 0 and drives csb0/web0/addr0/din0 itself, one operation per clock. It samples dout0 and compares it against the expected background, then reports pass/fail, the first failing address and element, and an error count. Muxing between BIST and functional traffic is outside this block.

## Interface
- DATA_WIDTH, 2, macro word width
- ADDR_WIDTH, 4, macro address width; N = 2^ADDR_WIDTH words
- ERR_W, 8, width of error counter
- clk0  in  1  clock; all state on rising edge
- rst0_n  in  1  reset, asynchronous assert, active low
- start  in  1  begin test; sampled only in IDLE
- busy  out  1  test in progress
- done  out  1  test finished; held until next accepted start
- fail  out  1  at least one mismatch seen in current/last run
- fail_addr  out  ADDR_WIDTH  address of first mismatch
- fail_elem  out  3  march element index (0-5) of first mismatch
- err_count  out  ERR_W  mismatch count, saturating at all-ones
- csb0  out  1  macro chip select, active low
- web0  out  1  macro write enable, active low
- addr0  out  ADDR_WIDTH  macro address
- din0  out  DATA_WIDTH  macro write data
- dout0  in  DATA_WIDTH  macro read data

## Operation
- Reset values: busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, err_count=0, csb0=1, web0=1, addr0=0, din0=0. Reset mid-run aborts immediately to IDLE with the macro deselected.
- States: IDLE -> RUN on start; RUN -> DRAIN after the last op is issued; DRAIN -> DONE after 2 cycles; DONE -> RUN on start (DONE behaves like IDLE plus done=1).
- Accepting start clears fail, fail_addr, fail_elem, err_count and done, and sets busy.
- start while busy is ignored.
- Elements, with background B0 = all zeros and B1 = all ones:
  - E0 up (w B0)
  - E1 up (r B0, w B1)
  - E2 up (r B1, w B0)
  - E3 down (r B0, w B1)
  - E4 down (r B1, w B0)
  - E5 up (r B0)
- Up order is 0..N-1; down order is N-1..0. In two-op elements both ops target the same address before it advances. Total ops = 10N.
- Read op: csb0=0, web0=1, din0=0. Write op: csb0=0, web0=0, din0=background. Outside RUN: csb0=1, web0=1.
- Compare pipeline carries valid, address, element and expected data for 2 stages, aligned with dout0.
- On a mismatch (any bit of dout0 differs from expected):
  - fail is set.
  - err_count increments, saturating.
  - fail_addr and fail_elem are loaded only on the first mismatch of the run.

## Timing
- start high at rising edge 0 in IDLE/DONE: the first op is driven after edge 0; op k (1-based) is presented during cycle k and captured by the macro at edge k.
- Read issued in cycle k: dout0 is sampled and compared at edge k+1. The clock period must exceed the macro's read delay plus setup.
- Last op is presented in cycle 10N. busy falls and done rises at edge 10N+2 (edge 162 for N=16).
- fail/err_count updates from the final compare are visible in the same cycle done rises.
- Two-op elements: addr0 holds for 2 cycles. Element boundaries have no idle cycles.

## Structure
- Package sram_bist_pkg holds:
  - march element enum (E0-E5)
  - op encoding (READ/WRITE)
  - per-element direction, op count and background constants
  - FSM state enum
- Sub-module sram_bist_addr_gen: loadable up/down address counter with terminal-count flag (0 or N-1 depending on direction).
- The top holds the FSM, op sequencing, compare pipeline and result registers.

## Test plan
- Fault-free behavioural macro, N=16, pulse start: addr0/web0 follow the March C- sequence; done at edge 162; fail=0, err_count=0.
- Bit 0 of word 5 stuck at 1: fail=1, fail_addr=5, fail_elem=1, err_count=3 (E1, E3 and E5 reads).
- Bit 1 of word 15 stuck at 0: fail_addr=15, fail_elem=2, err_count=2 (E2 and E4 reads).
- Check addr0 during E3: sequence 15,15,14,14,…,0,0. Check E0: 0..15 with web0=0, din0=2'b00.
- Assert rst0_n low at cycle 50: csb0=1 and busy=0 immediately. After release, start runs a full clean test.
- start pulsed at cycle 20 during a run is ignored (done still at edge 162). start after done clears the flags and reruns.
